mem_arbiter_rr: RTL and testbench
=================================

# mem_arbiter_rr

Parametrised N-port memory arbiter sitting between the cache front-ends (icache, dcache, prefetcher, …) and main memory. Each cycle it picks one requester by priority class, then round-robin within the class with starvation promotion, and drives the single memory command port. It also tracks outstanding load tags, so returning data is routed only to the port that issued the load.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters; port 0 is the lowest index for round-robin.
- NUM_TAGS, 16, memory tag space; tag 0 means "none", usable tags are 1..NUM_TAGS-1.
- STARVE_LIMIT, 8, cycles a port may wait before being promoted to high priority.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  [NUM_PORTS]  request present.
- req_prior  in  [NUM_PORTS]  1 = high-priority class.
- req_store  in  [NUM_PORTS]  1 = store, 0 = load.
- req_addr  in  [NUM_PORTS] x ADDR  request address.
- req_data  in  [NUM_PORTS] x MEM_BLOCK  store data; ignored for loads.
- req_accepted  out  [NUM_PORTS]  one-hot; request consumed this cycle.
- req_tag  out  MEM_TAG  tag given to the accepted load; 0 for stores or no accept.
- resp_valid  out  [NUM_PORTS]  one-hot; returning data belongs to this port.
- resp_tag  out  MEM_TAG  returning tag (mem2proc_data_tag).
- resp_data  out  MEM_BLOCK  returning data (mem2proc_data).
- proc2mem_command  out  MEM_COMMAND  MEM_NONE/MEM_LOAD/MEM_STORE.
- proc2mem_addr  out  ADDR  address of the granted request.
- proc2mem_data  out  MEM_BLOCK  data of the granted request.
- mem2proc_transaction_tag  in  MEM_TAG  nonzero = load accepted by memory this cycle.
- mem2proc_data  in  MEM_BLOCK  returning data.
- mem2proc_data_tag  in  MEM_TAG  nonzero = data return for that tag.
- outstanding  out  $clog2(NUM_TAGS)+1  count of in-flight loads.
- tag_err  out  1  sticky; data returned for a tag not in the table.

## Operation
- Effective priority of port i: req_prior[i] OR (age[i] == STARVE_LIMIT).
- Eligible: req_valid[i] AND (req_store[i] OR outstanding < NUM_TAGS-1). A load is ineligible while all tags are in flight; stores are never blocked.
- Grant: among eligible ports, the high class beats the low class. Within a class, the first eligible port at or after rr_ptr, scanning upward and wrapping, wins.
- With a grant: proc2mem_* carry the winner's fields, and command is MEM_STORE or MEM_LOAD. With no grant: command MEM_NONE, addr/data '0.
- Acceptance: a store is accepted whenever granted. A load is accepted iff mem2proc_transaction_tag != 0. req_accepted[winner]=1 only on acceptance; req_tag = transaction tag for accepted loads.
- Tag table, per tag: valid bit plus owner index. An accepted load sets valid[tag] and owner[tag]=winner.
- Return with mem2proc_data_tag=T != 0:
  - if valid[T]: resp_valid[owner[T]]=1 and valid[T] is cleared;
  - otherwise: no resp_valid is raised and tag_err is set.
- Same-cycle return of T and new accept of T: the accept wins (valid stays 1, owner updated). The return is still routed to the old owner.
- outstanding: +1 on load accept, −1 on valid return, unchanged when both happen. It never exceeds NUM_TAGS-1.
- rr_ptr advances to (winner+1) mod NUM_PORTS only on acceptance. It holds on a rejected load.
- age[i]: cleared on accept of i or when req_valid[i]=0. Otherwise it increments each cycle i is valid and not accepted, saturating at STARVE_LIMIT.

## Timing
- Grant, proc2mem_*, req_accepted, req_tag and resp_* are combinational, in the same cycle as their inputs.
- rr_ptr, age, tag table, outstanding and tag_err update on posedge clock.
- Load latency through the block: 0 cycles. Response routing: 0 cycles.
- Reset (asynchronous, any time, including mid-transaction):
  - rr_ptr=0, all age=0, all tag valid=0, outstanding=0, tag_err=0.
  - Outputs then depend only on current inputs: with no requests, all outputs are 0 and command is MEM_NONE.
  - Returns that arrive after reset for tags issued before it set tag_err.
- The requester must hold req_* stable until req_accepted. A request dropped before acceptance is legal and clears its age.

## Test plan
- Contention, NUM_PORTS=4: all ports issue low-priority loads, memory always returns tag 1..15. Grants must run 0,1,2,3,0; rr_ptr=1 after the first accept.
- Priority and promotion, STARVE_LIMIT=3: port 2 has prior=1, port 0 low, and memory rejects loads (tag 0) for 3 cycles. Port 2 is granted every cycle and port 0's age reaches 3. Once port 0 is promoted and memory accepts, port 0 wins.
- Tag exhaustion, NUM_TAGS=4: accept 3 loads with tags 1,2,3 and no returns. outstanding=3; the next load gets MEM_NONE while a store from another port still gets MEM_STORE and is accepted. A return of tag 2 reopens loads the next cycle.
- Routing: port 1 loads tag 5, port 3 loads tag 6. Return 6 then 5 gives resp_valid=4'b1000, then 4'b0010, and outstanding goes 2→1→0.
- Collision: tag 7 returns while a new load from port 0 is accepted with tag 7. The old owner gets the response, owner[7]=0, valid[7]=1 and outstanding is unchanged.
- Reset mid-op: assert reset with 2 loads in flight. All state returns to 0; a later return of tag 1 sets tag_err=1 with no resp_valid.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// N-port memory arbiter: priority class, then round-robin with starvation promotion.
// Tracks in-flight load tags so each data return is routed to the port that issued it.
module mem_arbiter_rr #(
  parameter int NUM_PORTS    = 2,
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = 32,
  parameter int BLOCK_W      = 64,
  localparam int TAG_W       = $clog2(NUM_TAGS),
  localparam int CNT_W       = $clog2(NUM_TAGS) + 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                req_valid,
  input  logic [NUM_PORTS-1:0]                req_prior,
  input  logic [NUM_PORTS-1:0]                req_store,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NUM_PORTS-1:0][BLOCK_W-1:0]   req_data,
  output logic [NUM_PORTS-1:0]                req_accepted,
  output logic [TAG_W-1:0]                    req_tag,
  output logic [NUM_PORTS-1:0]                resp_valid,
  output logic [TAG_W-1:0]                    resp_tag,
  output logic [BLOCK_W-1:0]                  resp_data,
  output logic [1:0]                          proc2mem_command,
  output logic [ADDR_W-1:0]                   proc2mem_addr,
  output logic [BLOCK_W-1:0]                  proc2mem_data,
  input  logic [TAG_W-1:0]                    mem2proc_transaction_tag,
  input  logic [BLOCK_W-1:0]                  mem2proc_data,
  input  logic [TAG_W-1:0]                    mem2proc_data_tag,
  output logic [CNT_W-1:0]                    outstanding,
  output logic                                tag_err
);

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] TAG_MAX = CNT_W'(NUM_TAGS - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PORTS - 1);

  logic [PTR_W-1:0]                 rr_ptr;
  logic [NUM_PORTS-1:0][AGE_W-1:0]  age;
  logic [NUM_TAGS-1:0]              tag_valid;
  logic [NUM_TAGS-1:0][PTR_W-1:0]   tag_owner;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] high;
  logic [NUM_PORTS-1:0] cand;
  logic [PTR_W-1:0]     winner;
  logic                 grant;
  logic                 accept;
  logic                 load_acc;
  logic                 ret_hit;
  logic                 ret_miss;

  // Loads stall once every usable tag is in flight; stores never need a tag.
  always_comb begin
    eligible = '0;
    high     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = req_valid[i] & (req_store[i] | (outstanding < TAG_MAX));
      high[i]     = eligible[i] & (req_prior[i] | (age[i] == AGE_MAX));
    end
    cand = (|high) ? high : eligible;
  end

  always_comb begin
    int j;
    j      = 0;
    winner = '0;
    grant  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!grant && cand[j]) begin
        grant  = 1'b1;
        winner = PTR_W'(j);
      end
    end
  end

  always_comb begin
    accept   = grant & (req_store[winner] | (mem2proc_transaction_tag != '0));
    load_acc = accept & ~req_store[winner];
    ret_hit  = (mem2proc_data_tag != '0) &  tag_valid[mem2proc_data_tag];
    ret_miss = (mem2proc_data_tag != '0) & ~tag_valid[mem2proc_data_tag];
  end

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    req_accepted     = '0;
    req_tag          = '0;
    resp_valid       = '0;
    resp_tag         = mem2proc_data_tag;
    resp_data        = mem2proc_data;
    if (grant) begin
      proc2mem_command = req_store[winner] ? MEM_STORE : MEM_LOAD;
      proc2mem_addr    = req_addr[winner];
      proc2mem_data    = req_data[winner];
    end
    if (accept)   req_accepted[winner] = 1'b1;
    if (load_acc) req_tag = mem2proc_transaction_tag;
    if (ret_hit)  resp_valid[tag_owner[mem2proc_data_tag]] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      age         <= '0;
      tag_valid   <= '0;
      tag_owner   <= '0;
      outstanding <= '0;
      tag_err     <= 1'b0;
    end else begin
      if (accept) rr_ptr <= (winner == PTR_LAST) ? '0 : winner + 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!req_valid[i] || (accept && (winner == PTR_W'(i))))
          age[i] <= '0;
        else if (age[i] != AGE_MAX)
          age[i] <= age[i] + 1'b1;
      end
      // A same-cycle accept of the returning tag overrides the clear.
      if (ret_hit) tag_valid[mem2proc_data_tag] <= 1'b0;
      if (load_acc) begin
        tag_valid[mem2proc_transaction_tag] <= 1'b1;
        tag_owner[mem2proc_transaction_tag] <= winner;
      end
      if (load_acc && !ret_hit)
        outstanding <= outstanding + 1'b1;
      else if (!load_acc && ret_hit)
        outstanding <= outstanding - 1'b1;
      if (ret_miss) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scenario bench for mem_arbiter_rr: 4 ports, 8 tags, starvation limit 3.
// Expected grant/accept/route results are queued as stimulus is applied, then popped and compared.
module tb_mem_arbiter_rr;

  localparam int NP = 4;
  localparam int NT = 8;
  localparam int SL = 3;
  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0]        req_valid, req_prior, req_store, req_accepted, resp_valid;
  logic [3:0][31:0]  req_addr;
  logic [3:0][63:0]  req_data;
  logic [2:0]        req_tag, resp_tag, mem2proc_transaction_tag, mem2proc_data_tag;
  logic [63:0]       resp_data, proc2mem_data, mem2proc_data;
  logic [1:0]        proc2mem_command;
  logic [31:0]       proc2mem_addr;
  logic [3:0]        outstanding;
  logic              tag_err;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [3:0]  acc;
    logic [2:0]  rtag;
    logic [3:0]  resp;
    logic [31:0] addr;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_rr #(.NUM_PORTS(NP), .NUM_TAGS(NT), .STARVE_LIMIT(SL),
                   .ADDR_W(32), .BLOCK_W(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_prior(req_prior), .req_store(req_store),
    .req_addr(req_addr), .req_data(req_data),
    .req_accepted(req_accepted), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_transaction_tag(mem2proc_transaction_tag),
    .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag),
    .outstanding(outstanding), .tag_err(tag_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] addr_of(input int p);
    return 32'h1000 + 32'(p * 16);
  endfunction

  function automatic logic [63:0] data_of(input int p);
    return 64'hD000_0000_0000_0000 + 64'(p);
  endfunction

  function automatic obs_t mk(input logic [1:0] c, input logic [3:0] a, input logic [2:0] t,
                              input logic [3:0] r, input logic [31:0] ad);
    obs_t e;
    e = '{cmd: c, acc: a, rtag: t, resp: r, addr: ad};
    return e;
  endfunction

  function obs_t observe();
    return {proc2mem_command, req_accepted, req_tag, resp_valid, proc2mem_addr};
  endfunction

  // Drive one cycle of stimulus just after the falling edge; outputs settle before the next rise.
  task automatic apply(input logic [3:0] v, input logic [3:0] p, input logic [3:0] s,
                       input logic [2:0] tt, input logic [2:0] dt);
    @(negedge clock);
    req_valid = v;
    req_prior = p;
    req_store = s;
    mem2proc_transaction_tag = tt;
    mem2proc_data_tag = dt;
    mem2proc_data = 64'hA5A5_0000_0000_0000 | 64'(dt);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    req_valid = '0; req_prior = '0; req_store = '0;
    mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    @(negedge clock);
    #1;
    o = observe();
    n_checks++;
    if (o !== mk(C_NONE, 4'b0, 3'd0, 4'b0, 32'h0)) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", o, mk(C_NONE, 4'b0, 3'd0, 4'b0, 32'h0));
    end
    n_checks++;
    if (outstanding !== 4'd0 || tag_err !== 1'b0 || proc2mem_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_state: outstanding=%0d tag_err=%b data=%h, expected 0 0 0",
               outstanding, tag_err, proc2mem_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_contention();
    int   w [5];
    obs_t e, o;
    w = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(4'hF, 4'h0, 4'h0, 3'(k + 1), 3'd0);
      exp_q.push_back(mk(C_LOAD, 4'(1 << w[k]), 3'(k + 1), 4'b0, addr_of(w[k])));
      e = exp_q.pop_front(); o = observe(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL contention_grant[%0d]: got %h expected %h", k, o, e);
      end
    end
    for (int k = 0; k < 5; k++) begin
      apply(4'h0, 4'h0, 4'h0, 3'd0, 3'(k + 1));
      exp_q.push_back(mk(C_NONE, 4'b0, 3'd0, 4'(1 << w[k]), 32'h0));
      e = exp_q.pop_front(); o = observe(); n_checks++;
      if (o !== e || outstanding !== 4'(5 - k)) begin
        n_fail++;
        $display("FAIL contention_drain[%0d]: got %h out=%0d expected %h out=%0d",
                 k, o, outstanding, e, 5 - k);
      end
    end
  endtask

  task automatic test_priority();
    obs_t e, o;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(4'b0101, 4'b0100, 4'b0000, (k == 3) ? 3'd1 : 3'd0, 3'd0);
      if (k < 3) exp_q.push_back(mk(C_LOAD, 4'b0000, 3'd0, 4'b0, addr_of(2)));
      else       exp_q.push_back(mk(C_LOAD, 4'b0001, 3'd1, 4'b0, addr_of(0)));
      e = exp_q.pop_front(); o = observe(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL priority[%0d]: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_exhaustion();
    obs_t e, o;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      apply(4'b0001, 4'h0, 4'h0, 3'(k + 1), 3'd0);
      exp_q.push_back(mk(C_LOAD, 4'b0001, 3'(k + 1), 4'b0, addr_of(0)));
      e = exp_q.pop_front(); o = observe(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL exhaust_fill[%0d]: got %h expected %h", k, o, e);
      end
    end
    apply(4'b0011, 4'h0, 4'b0010, 3'd1, 3'd0);
    exp_q.push_back(mk(C_STORE, 4'b0010, 3'd0, 4'b0, addr_of(1)));
    apply_check_store: begin
      e = exp_q.pop_front(); o = observe(); n_checks++;
      if (o !== e || proc2mem_data !== data_of(1) || outstanding !== 4'd7) begin
        n_fail++;
        $display("FAIL exhaust_store: got %h data=%h out=%0d expected %h data=%h out=7",
                 o, proc2mem_data, outstanding, e, data_of(1));
      end
    end
    for (int k = 0; k < 3; k++) begin
      apply(4'b0001, 4'h0, 4'h0, 3'd2, (k == 1) ? 3'd2 : 3'd0);
      case (k)
        0: exp_q.push_back(mk(C_NONE, 4'b0, 3'd0, 4'b0, 32'h0));
        1: exp_q.push_back(mk(C_NONE, 4'b0, 3'd0, 4'b0001, 32'h0));
        default: exp_q.push_back(mk(C_LOAD, 4'b0001, 3'd2, 4'b0, addr_of(0)));
      endcase
      e = exp_q.pop_front(); o = observe(); n_checks++;
      if (o !== e || outstanding !== ((k == 2) ? 4'd6 : 4'd7)) begin
        n_fail++;
        $display("FAIL exhaust_reopen[%0d]: got %h out=%0d expected %h", k, o, outstanding, e);
      end
    end
  endtask

  task automatic test_routing();
    obs_t e, o;
    logic [3:0] exp_out [4];
    exp_out = '{4'd0, 4'd1, 4'd2, 4'd1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin apply(4'b0010, 4'h0, 4'h0, 3'd5, 3'd0);
                 exp_q.push_back(mk(C_LOAD, 4'b0010, 3'd5, 4'b0, addr_of(1))); end
        1: begin apply(4'b1000, 4'h0, 4'h0, 3'd6, 3'd0);
                 exp_q.push_back(mk(C_LOAD, 4'b1000, 3'd6, 4'b0, addr_of(3))); end
        2: begin apply(4'b0000, 4'h0, 4'h0, 3'd0, 3'd6);
                 exp_q.push_back(mk(C_NONE, 4'b0, 3'd0, 4'b1000, 32'h0)); end
        default: begin apply(4'b0000, 4'h0, 4'h0, 3'd0, 3'd5);
                 exp_q.push_back(mk(C_NONE, 4'b0, 3'd0, 4'b0010, 32'h0)); end
      endcase
      e = exp_q.pop_front(); o = observe(); n_checks++;
      if (o !== e || outstanding !== exp_out[k]) begin
        n_fail++;
        $display("FAIL routing[%0d]: got %h out=%0d expected %h out=%0d",
                 k, o, outstanding, e, exp_out[k]);
      end
    end
    n_checks++;
    if (resp_data !== 64'hA5A5_0000_0000_0005 || resp_tag !== 3'd5) begin
      n_fail++;
      $display("FAIL routing_data: got tag %0d data %h expected 5 a5a5000000000005", resp_tag, resp_data);
    end
    apply(4'b0000, 4'h0, 4'h0, 3'd0, 3'd0);
    n_checks++;
    if (outstanding !== 4'd0 || tag_err !== 1'b0) begin
      n_fail++;
      $display("FAIL routing_final: out=%0d tag_err=%b expected 0 0", outstanding, tag_err);
    end
  endtask

  task automatic test_collision();
    obs_t e, o;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin apply(4'b0100, 4'h0, 4'h0, 3'd7, 3'd0);
                 exp_q.push_back(mk(C_LOAD, 4'b0100, 3'd7, 4'b0, addr_of(2))); end
        1: begin apply(4'b0001, 4'h0, 4'h0, 3'd7, 3'd7);
                 exp_q.push_back(mk(C_LOAD, 4'b0001, 3'd7, 4'b0100, addr_of(0))); end
        2: begin apply(4'b0000, 4'h0, 4'h0, 3'd0, 3'd7);
                 exp_q.push_back(mk(C_NONE, 4'b0, 3'd0, 4'b0001, 32'h0)); end
        default: begin apply(4'b0000, 4'h0, 4'h0, 3'd0, 3'd0);
                 exp_q.push_back(mk(C_NONE, 4'b0, 3'd0, 4'b0, 32'h0)); end
      endcase
      e = exp_q.pop_front(); o = observe(); n_checks++;
      if (o !== e || outstanding !== ((k == 0 || k == 3) ? 4'd0 : 4'd1) || tag_err !== 1'b0) begin
        n_fail++;
        $display("FAIL collision[%0d]: got %h out=%0d err=%b expected %h", k, o, outstanding, tag_err, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    do_reset();
    apply(4'b0011, 4'h0, 4'h0, 3'd1, 3'd0);
    exp_q.push_back(mk(C_LOAD, 4'b0001, 3'd1, 4'b0, addr_of(0)));
    apply(4'b0010, 4'h0, 4'h0, 3'd2, 3'd0);
    exp_q.push_back(mk(C_LOAD, 4'b0010, 3'd2, 4'b0, addr_of(1)));
    // Both loads were queued before either sample; the second sample is the one taken now.
    e = exp_q.pop_back(); o = observe(); n_checks++;
    if (o !== e || outstanding !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_mid_load: got %h out=%0d expected %h out=1", o, outstanding, e);
    end
    exp_q.delete();
    apply(4'b0000, 4'h0, 4'h0, 3'd0, 3'd0);
    n_checks++;
    if (outstanding !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_mid_inflight: out=%0d expected 2", outstanding);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (outstanding !== 4'd0 || tag_err !== 1'b0 || observe() !== mk(C_NONE, 4'b0, 3'd0, 4'b0, 32'h0)) begin
      n_fail++;
      $display("FAIL reset_mid_async: out=%0d err=%b obs=%h expected all 0", outstanding, tag_err, observe());
    end
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin apply(4'b1001, 4'h0, 4'h0, 3'd3, 3'd0);
                 exp_q.push_back(mk(C_LOAD, 4'b0001, 3'd3, 4'b0, addr_of(0))); end
        1: begin apply(4'b0000, 4'h0, 4'h0, 3'd0, 3'd1);
                 exp_q.push_back(mk(C_NONE, 4'b0, 3'd0, 4'b0, 32'h0)); end
        default: begin apply(4'b0000, 4'h0, 4'h0, 3'd0, 3'd0);
                 exp_q.push_back(mk(C_NONE, 4'b0, 3'd0, 4'b0, 32'h0)); end
      endcase
      e = exp_q.pop_front(); o = observe(); n_checks++;
      if (o !== e || tag_err !== ((k == 2) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL reset_mid_after[%0d]: got %h err=%b expected %h err=%b",
                 k, o, tag_err, e, (k == 2));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_prior = '0; req_store = '0;
    mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;
    for (int i = 0; i < NP; i++) begin
      req_addr[i] = addr_of(i);
      req_data[i] = data_of(i);
    end
    test_reset();
    test_contention();
    test_priority();
    test_exhaustion();
    test_routing();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
